// File: rtl/wb_retire_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_retire_queue_if
// Purpose  : Bundle of MEM-side push signals, register-file / HI-LO write
//            ports, trace port and status of the write-back retire queue.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_retire_queue_if #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 2
);
  // MEM stage push side
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [31:0]               in_pc;
  logic                      in_rf_we;
  logic [AW-1:0]             in_rf_waddr;
  logic [DW-1:0]             in_rf_wdata;
  logic                      in_hi_we;
  logic                      in_lo_we;
  logic [DW-1:0]             in_hi;
  logic [DW-1:0]             in_lo;

  // Register file / HI-LO write side
  logic                      rf_ready;
  logic                      rf_we;
  logic [AW-1:0]             rf_waddr;
  logic [DW-1:0]             rf_wdata;
  logic                      hi_we;
  logic                      lo_we;
  logic [DW-1:0]             hi_wdata;
  logic [DW-1:0]             lo_wdata;

  // Trace and status
  logic [31:0]               debug_wb_pc;
  logic [3:0]                debug_wb_rf_wen;
  logic [AW-1:0]             debug_wb_rf_wnum;
  logic [DW-1:0]             debug_wb_rf_wdata;
  logic [31:0]               retire_cnt;
  logic [$clog2(DEPTH):0]    count;

  // Pipeline / register-file side driving the queue
  modport master (
    output flush, in_valid, in_pc, in_rf_we, in_rf_waddr, in_rf_wdata,
           in_hi_we, in_lo_we, in_hi, in_lo, rf_ready,
    input  in_ready, rf_we, rf_waddr, rf_wdata, hi_we, lo_we, hi_wdata,
           lo_wdata, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum,
           debug_wb_rf_wdata, retire_cnt, count
  );

  // The queue itself
  modport slave (
    input  flush, in_valid, in_pc, in_rf_we, in_rf_waddr, in_rf_wdata,
           in_hi_we, in_lo_we, in_hi, in_lo, rf_ready,
    output in_ready, rf_we, rf_waddr, rf_wdata, hi_we, lo_we, hi_wdata,
           lo_wdata, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum,
           debug_wb_rf_wdata, retire_cnt, count
  );
endinterface
`default_nettype wire

// File: rtl/wb_retire_queue.sv
`default_nettype none
// ============================================================================
// Module   : wb_retire_queue
// Purpose  : DEPTH-entry in-order retire FIFO between MEM and the register
//            file. Head entry drives the GPR / HI-LO write ports and the
//            trace port combinationally in the cycle it retires.
// Revision : 1.0 - initial release
// ============================================================================
module wb_retire_queue #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int DEPTH   = 2,
  parameter int HILO_EN = 1
) (
  input  wire              clk,
  input  wire              rst,
  wb_retire_queue_if.slave bus
);

  localparam int                c_PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_PW:0]     c_DEPTH_CNT = (c_PW + 1)'(DEPTH);

  // Entry storage (no reset: contents are only meaningful below r_count)
  logic [31:0]   r_pc_mem    [DEPTH];
  logic          r_rfwe_mem  [DEPTH];
  logic [AW-1:0] r_waddr_mem [DEPTH];
  logic [DW-1:0] r_wdata_mem [DEPTH];
  logic          r_hiwe_mem  [DEPTH];
  logic          r_lowe_mem  [DEPTH];
  logic [DW-1:0] r_hi_mem    [DEPTH];
  logic [DW-1:0] r_lo_mem    [DEPTH];

  logic [c_PW-1:0] r_rd_ptr;
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW:0]   r_count;
  logic [31:0]     r_retire_cnt;

  logic w_in_ready;
  logic w_push;
  logic w_pop;
  logic w_rf_we;

  // A full queue never accepts, even when it retires in the same cycle
  assign w_in_ready = (r_count < c_DEPTH_CNT);
  assign w_push     = bus.in_valid & w_in_ready & ~bus.flush;
  assign w_pop      = (r_count != '0) & bus.rf_ready & ~bus.flush;

  // Capture the presented entry at the write pointer on accept
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= bus.in_pc;
      r_rfwe_mem[r_wr_ptr]  <= bus.in_rf_we;
      r_waddr_mem[r_wr_ptr] <= bus.in_rf_waddr;
      r_wdata_mem[r_wr_ptr] <= bus.in_rf_wdata;
      r_hiwe_mem[r_wr_ptr]  <= bus.in_hi_we;
      r_lowe_mem[r_wr_ptr]  <= bus.in_lo_we;
      r_hi_mem[r_wr_ptr]    <= bus.in_hi;
      r_lo_mem[r_wr_ptr]    <= bus.in_lo;
    end
  end

  // Pointers and occupancy; flush wins over any push or pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Free-running retirement counter; survives flush, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retire_cnt <= '0;
    end else if (w_pop) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  // r0 writes still retire but never reach the register file
  assign w_rf_we = w_pop & r_rfwe_mem[r_rd_ptr] & (r_waddr_mem[r_rd_ptr] != '0);

  assign bus.in_ready          = w_in_ready;
  assign bus.rf_we             = w_rf_we;
  assign bus.rf_waddr          = w_pop ? r_waddr_mem[r_rd_ptr] : '0;
  assign bus.rf_wdata          = w_pop ? r_wdata_mem[r_rd_ptr] : '0;
  assign bus.hi_wdata          = w_pop ? r_hi_mem[r_rd_ptr]    : '0;
  assign bus.lo_wdata          = w_pop ? r_lo_mem[r_rd_ptr]    : '0;
  assign bus.debug_wb_pc       = w_pop ? r_pc_mem[r_rd_ptr]    : 32'd0;
  assign bus.debug_wb_rf_wen   = {4{w_rf_we}};
  assign bus.debug_wb_rf_wnum  = bus.rf_waddr;
  assign bus.debug_wb_rf_wdata = bus.rf_wdata;
  assign bus.retire_cnt        = r_retire_cnt;
  assign bus.count             = r_count;

  // HI/LO write enables exist only when the HI/LO path is built
  generate
    if (HILO_EN != 0) begin : g_hilo_on
      assign bus.hi_we = w_pop & r_hiwe_mem[r_rd_ptr];
      assign bus.lo_we = w_pop & r_lowe_mem[r_rd_ptr];
    end else begin : g_hilo_off
      assign bus.hi_we = 1'b0;
      assign bus.lo_we = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_wb_retire_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_retire_queue
// Purpose  : Directed self-checking bench for wb_retire_queue (HILO_EN=1 and
//            a HILO_EN=0 twin fed the same stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_retire_queue;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  wb_retire_queue_if #(.DW(32), .AW(5), .DEPTH(2)) ifa ();
  wb_retire_queue_if #(.DW(32), .AW(5), .DEPTH(2)) ifb ();

  wb_retire_queue #(.DW(32), .AW(5), .DEPTH(2), .HILO_EN(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  wb_retire_queue #(.DW(32), .AW(5), .DEPTH(2), .HILO_EN(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  // Twin instance mirrors every input of the primary instance
  assign ifb.flush       = ifa.flush;
  assign ifb.in_valid    = ifa.in_valid;
  assign ifb.in_pc       = ifa.in_pc;
  assign ifb.in_rf_we    = ifa.in_rf_we;
  assign ifb.in_rf_waddr = ifa.in_rf_waddr;
  assign ifb.in_rf_wdata = ifa.in_rf_wdata;
  assign ifb.in_hi_we    = ifa.in_hi_we;
  assign ifb.in_lo_we    = ifa.in_lo_we;
  assign ifb.in_hi       = ifa.in_hi;
  assign ifb.in_lo       = ifa.in_lo;
  assign ifb.rf_ready    = ifa.rf_ready;

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic we, input logic [4:0] addr,
                       input logic [31:0] data, input logic hwe, input logic lwe,
                       input logic [31:0] hi, input logic [31:0] lo);
    ifa.in_valid    = 1'b1;
    ifa.in_pc       = pc;
    ifa.in_rf_we    = we;
    ifa.in_rf_waddr = addr;
    ifa.in_rf_wdata = data;
    ifa.in_hi_we    = hwe;
    ifa.in_lo_we    = lwe;
    ifa.in_hi       = hi;
    ifa.in_lo       = lo;
  endtask

  task automatic idle();
    ifa.in_valid = 1'b0;
    ifa.in_rf_we = 1'b0;
    ifa.in_hi_we = 1'b0;
    ifa.in_lo_we = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    ifa.flush       = 1'b0;
    ifa.rf_ready    = 1'b0;
    ifa.in_pc       = '0;
    ifa.in_rf_waddr = '0;
    ifa.in_rf_wdata = '0;
    ifa.in_hi       = '0;
    ifa.in_lo       = '0;
    idle();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_count",    ifa.count, 0);
    chk("rst_in_ready", ifa.in_ready, 1);
    chk("rst_rf_we",    ifa.rf_we, 0);
    chk("rst_dbg_pc",   ifa.debug_wb_pc, 0);
    chk("rst_rcnt",     ifa.retire_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single push then retire next cycle
    @(negedge clk);
    ifa.rf_ready = 1'b1;
    drive(32'hBFC0_0000, 1'b1, 5'd3, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("t1_rf_we",   ifa.rf_we, 1);
    chk("t1_waddr",   ifa.rf_waddr, 3);
    chk("t1_wdata",   ifa.rf_wdata, 32'h1234);
    chk("t1_wen",     ifa.debug_wb_rf_wen, 4'hF);
    chk("t1_wnum",    ifa.debug_wb_rf_wnum, 3);
    chk("t1_dbg_pc",  ifa.debug_wb_pc, 32'hBFC0_0000);
    @(negedge clk);
    #1;
    chk("t1_rcnt",    ifa.retire_cnt, 1);
    chk("t1_count",   ifa.count, 0);

    // Fill with rf_ready low, third push refused, then drain in order
    ifa.rf_ready = 1'b0;
    drive(32'h100, 1'b1, 5'd1, 32'h11, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    chk("t2_count1",  ifa.count, 1);
    chk("t2_ready1",  ifa.in_ready, 1);
    drive(32'h104, 1'b1, 5'd2, 32'h22, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    chk("t2_count2",  ifa.count, 2);
    chk("t2_ready2",  ifa.in_ready, 0);
    drive(32'h108, 1'b1, 5'd4, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    chk("t2_count_full", ifa.count, 2);
    chk("t2_no_retire",  ifa.rf_we, 0);
    idle();
    ifa.rf_ready = 1'b1;
    #1;
    chk("t2_r1_we",    ifa.rf_we, 1);
    chk("t2_r1_waddr", ifa.rf_waddr, 1);
    chk("t2_r1_wdata", ifa.rf_wdata, 32'h11);
    chk("t2_r1_pc",    ifa.debug_wb_pc, 32'h100);
    @(negedge clk);
    #1;
    chk("t2_r2_waddr", ifa.rf_waddr, 2);
    chk("t2_r2_wdata", ifa.rf_wdata, 32'h22);
    chk("t2_r2_count", ifa.count, 1);
    @(negedge clk);
    #1;
    chk("t2_end_count", ifa.count, 0);
    chk("t2_end_we",    ifa.rf_we, 0);
    chk("t2_end_rcnt",  ifa.retire_cnt, 3);

    // Write to r0 retires without a register-file write
    drive(32'h200, 1'b1, 5'd0, 32'h55, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("t3_rf_we",  ifa.rf_we, 0);
    chk("t3_wen",    ifa.debug_wb_rf_wen, 0);
    chk("t3_dbg_pc", ifa.debug_wb_pc, 32'h200);
    chk("t3_rcnt0",  ifa.retire_cnt, 3);
    @(negedge clk);
    #1;
    chk("t3_rcnt1",  ifa.retire_cnt, 4);

    // HI/LO write, enabled vs disabled instance
    drive(32'h250, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'hA, 32'hB);
    @(negedge clk);
    idle();
    #1;
    chk("t4_a_hi_we", ifa.hi_we, 1);
    chk("t4_a_lo_we", ifa.lo_we, 1);
    chk("t4_a_hi",    ifa.hi_wdata, 32'hA);
    chk("t4_a_lo",    ifa.lo_wdata, 32'hB);
    chk("t4_a_rf_we", ifa.rf_we, 0);
    chk("t4_b_hi_we", ifb.hi_we, 0);
    chk("t4_b_lo_we", ifb.lo_we, 0);
    @(negedge clk);
    #1;
    chk("t4_rcnt",    ifa.retire_cnt, 5);

    // Flush a full queue while a push is presented
    ifa.rf_ready = 1'b0;
    drive(32'h300, 1'b1, 5'd5, 32'h33, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    drive(32'h304, 1'b1, 5'd6, 32'h66, 1'b1, 1'b1, 32'h1, 32'h2);
    @(negedge clk);
    #1;
    chk("t5_full", ifa.count, 2);
    ifa.flush    = 1'b1;
    ifa.rf_ready = 1'b1;
    drive(32'h308, 1'b1, 5'd7, 32'h88, 1'b1, 1'b1, 32'h3, 32'h4);
    #1;
    chk("t5_fl_rf_we", ifa.rf_we, 0);
    chk("t5_fl_hi_we", ifa.hi_we, 0);
    chk("t5_fl_dbgpc", ifa.debug_wb_pc, 0);
    @(negedge clk);
    ifa.flush = 1'b0;
    idle();
    #1;
    chk("t5_count",  ifa.count, 0);
    chk("t5_ready",  ifa.in_ready, 1);
    chk("t5_rf_we",  ifa.rf_we, 0);
    chk("t5_rcnt",   ifa.retire_cnt, 5);
    // Pointers restart cleanly after flush
    drive(32'h400, 1'b1, 5'd7, 32'h77, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("t5_post_waddr", ifa.rf_waddr, 7);
    chk("t5_post_wdata", ifa.rf_wdata, 32'h77);
    chk("t5_post_pc",    ifa.debug_wb_pc, 32'h400);

    // Asynchronous reset between edges with two entries queued
    @(negedge clk);
    #1;
    chk("t6_rcnt_pre", ifa.retire_cnt, 6);
    ifa.rf_ready = 1'b0;
    drive(32'h500, 1'b1, 5'd8, 32'h88, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    drive(32'h504, 1'b1, 5'd9, 32'h99, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("t6_count2", ifa.count, 2);
    ifa.rf_ready = 1'b1;
    #1;
    chk("t6_head_we",    ifa.rf_we, 1);
    chk("t6_head_waddr", ifa.rf_waddr, 8);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_count", ifa.count, 0);
    chk("t6_rst_ready", ifa.in_ready, 1);
    chk("t6_rst_we",    ifa.rf_we, 0);
    chk("t6_rst_wen",   ifa.debug_wb_rf_wen, 0);
    chk("t6_rst_pc",    ifa.debug_wb_pc, 0);
    chk("t6_rst_rcnt",  ifa.retire_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_after_count", ifa.count, 0);
    chk("t6_after_rcnt",  ifa.retire_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_retire_queue.md
WB_RETIRE_QUEUE -- requirements
Module: wb_retire_queue

Interface
REQ-001 Parameter DW, default 32: register-file data width and HI/LO data width.
REQ-002 Parameter AW, default 5: register-file address width.
REQ-003 Parameter DEPTH, default 2: queue entries; power of two, at least 2.
REQ-004 Parameter HILO_EN, default 1: 1 enables the HI/LO write path; 0 ties hi_we and lo_we to 0.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 flush  in  1  discard all queued entries.
REQ-008 in_valid  in  1  MEM stage presents an entry.
REQ-009 in_ready  out  1  queue can accept an entry.
REQ-010 in_pc  in  32  PC of the entry.
REQ-011 in_rf_we, in_rf_waddr, in_rf_wdata  in  1/AW/DW  GPR write request.
REQ-012 in_hi_we, in_lo_we, in_hi, in_lo  in  1/1/DW/DW  HI/LO write request (divide/multiply result).
REQ-013 rf_ready  in  1  register file accepts a retirement this cycle.
REQ-014 rf_we, rf_waddr, rf_wdata  out  1/AW/DW  GPR write port.
REQ-015 hi_we, lo_we, hi_wdata, lo_wdata  out  1/1/DW/DW  HI/LO write port.
REQ-016 debug_wb_pc  out  32; debug_wb_rf_wen  out  4; debug_wb_rf_wnum  out  AW; debug_wb_rf_wdata  out  DW: trace port.
REQ-017 retire_cnt  out  32  count of retired entries.
REQ-018 count  out  log2(DEPTH)+1  current occupancy.

Function
REQ-019 The block SHALL be a DEPTH-entry FIFO with a read pointer, a write pointer and an occupancy counter; pointers SHALL wrap modulo DEPTH.
REQ-020 Accept (push) SHALL occur when in_valid & in_ready & !flush.
REQ-021 in_ready SHALL be (count < DEPTH); a full queue SHALL NOT accept in the same cycle it retires.
REQ-022 Retire (pop) SHALL occur when count != 0 & rf_ready & !flush.
REQ-023 An entry accepted at edge N SHALL be visible at the head, and eligible to retire, in the cycle after edge N.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-025 Outputs SHALL be combinational from the head entry, gated by retire.
REQ-026 rf_we SHALL be head.rf_we & retire & (head.rf_waddr != 0); a write to r0 SHALL retire with rf_we = 0.
REQ-027 hi_we and lo_we SHALL be head.hi_we / head.lo_we & retire & HILO_EN.
REQ-028 hi_wdata, lo_wdata, rf_waddr and rf_wdata SHALL be the head entry's fields when retiring, and 0 otherwise.
REQ-029 debug_wb_pc SHALL be head.pc when retiring, and 0 otherwise.
REQ-030 debug_wb_rf_wen SHALL be {4{rf_we}}; debug_wb_rf_wnum and debug_wb_rf_wdata SHALL equal rf_waddr and rf_wdata.
REQ-031 retire_cnt SHALL increment by 1 per retire and wrap from 0xFFFFFFFF to 0.
REQ-032 flush SHALL, at the next edge, clear count and both pointers and override any push.
REQ-033 During a flush cycle, retire and all write-enable outputs SHALL be 0.
REQ-034 retire_cnt SHALL NOT be cleared by flush.
REQ-035 Entry storage SHALL need no reset; only pointers, count and retire_cnt SHALL be reset.

Reset
REQ-036 While rst is high, count, both pointers and retire_cnt SHALL be 0, independent of clk.
REQ-037 While rst is high, in_ready SHALL be 1 and all write enables and debug outputs SHALL be 0.
REQ-038 Reset asserted mid-operation SHALL discard queued entries immediately, with no retirement in that cycle.
REQ-039 After rst deasserts, the first accept SHALL occur no earlier than the first rising edge.

Verification
REQ-040 Push pc=0xBFC00000, waddr=3, wdata=0x1234, rf_ready=1 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0x1234, debug_wb_rf_wen=0xF, retire_cnt=1.
REQ-041 rf_ready=0 and 3 pushes with DEPTH=2 -> in_ready=0 after 2 accepts, count=2; then rf_ready=1 -> in-order retires, one per cycle.
REQ-042 Push waddr=0, rf_we=1 -> retire occurs with rf_we=0, debug_wb_pc valid, retire_cnt increments.
REQ-043 Push in_hi_we=in_lo_we=1, hi=0xA, lo=0xB with HILO_EN=1 -> hi_we=lo_we=1, hi_wdata=0xA, lo_wdata=0xB; repeat with HILO_EN=0 -> hi_we=lo_we=0.
REQ-044 Queue full, flush=1 together with in_valid=1 -> count=0 next cycle, no write enable asserted, retire_cnt unchanged.
REQ-045 Assert rst asynchronously between edges with count=2 -> count=0, in_ready=1, outputs 0 before the next edge.
